// File: rtl/ptp_xfer.sv
// +----------------------------------------------------------------------------
// | ptp_xfer : beat-serial word assembler (write) and multi-channel word
// |            serialiser (read), both driven by edge-detected strobes.
// | Optional : define PTP_XFER_SYNC_EN for 2-flop strobe synchronisers.
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module ptp_xfer #(
  parameter int WORD_W = 32,
  parameter int BUS_W  = 8,
  parameter int NCH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  wr_strobe_i,
  input  logic [BUS_W-1:0]      wr_data_i,
  output logic [WORD_W-1:0]     word_o,
  output logic                  word_valid_o,
  input  logic                  rd_strobe_i,
  input  logic [NCH*WORD_W-1:0] rd_chan_i,
  output logic [BUS_W-1:0]      rd_data_o,
  output logic                  rd_last_o
);

  localparam int BEATS = WORD_W / BUS_W;
  localparam int TOTAL = NCH * BEATS;
  localparam int CNT_W = $clog2(BEATS);
  localparam int IDX_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);

  logic                    w_wr_s, w_rd_s, w_wr_edge, w_rd_edge;
  logic                    wr_prev_q, rd_prev_q;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [WORD_W-BUS_W-1:0] stage_q, stage_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic                    word_valid_q, word_valid_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic                    rd_busy_q, rd_busy_d;
  logic [NCH*WORD_W-1:0]   shadow_q, shadow_d;

`ifdef PTP_XFER_SYNC_EN
  logic [1:0] wr_sync_q, rd_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_q <= 2'b00;
      rd_sync_q <= 2'b00;
    end else begin
      wr_sync_q <= {wr_sync_q[0], wr_strobe_i};
      rd_sync_q <= {rd_sync_q[0], rd_strobe_i};
    end
  end

  assign w_wr_s = wr_sync_q[1];
  assign w_rd_s = rd_sync_q[1];
`else
  assign w_wr_s = wr_strobe_i;
  assign w_rd_s = rd_strobe_i;
`endif

  // History resets to 0, so a strobe already high at reset release is an edge.
  assign w_wr_edge = w_wr_s & ~wr_prev_q;
  assign w_rd_edge = w_rd_s & ~rd_prev_q;

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    stage_d      = stage_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    rd_idx_d     = rd_idx_q;
    rd_busy_d    = rd_busy_q;
    shadow_d     = rd_busy_q ? shadow_q : rd_chan_i;

    if (clear_i) begin
      wr_cnt_d  = '0;
      stage_d   = '0;
      word_d    = '0;
      rd_idx_d  = '0;
      rd_busy_d = 1'b0;
    end else begin
      if (w_wr_edge) begin
        if (wr_cnt_q == LAST_BEAT) begin
          word_d       = {wr_data_i, stage_q};
          word_valid_d = 1'b1;
          wr_cnt_d     = '0;
        end else begin
          stage_d[int'(wr_cnt_q)*BUS_W +: BUS_W] = wr_data_i;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
      end
      // Flat index walks beats of a channel first, then the next channel.
      if (w_rd_edge) begin
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_d  = '0;
          rd_busy_d = 1'b0;
        end else begin
          rd_idx_d  = rd_idx_q + IDX_W'(1);
          rd_busy_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b0;
      wr_cnt_q     <= '0;
      stage_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      rd_idx_q     <= '0;
      rd_busy_q    <= 1'b0;
      shadow_q     <= '0;
    end else begin
      wr_prev_q    <= w_wr_s;
      rd_prev_q    <= w_rd_s;
      wr_cnt_q     <= wr_cnt_d;
      stage_q      <= stage_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      rd_idx_q     <= rd_idx_d;
      rd_busy_q    <= rd_busy_d;
      shadow_q     <= shadow_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign rd_data_o    = shadow_q[int'(rd_idx_q)*BUS_W +: BUS_W];
  assign rd_last_o    = (rd_idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_ptp_xfer.sv
// +----------------------------------------------------------------------------
// | tb_ptp_xfer : randomized and directed bench for ptp_xfer (default build).
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_ptp_xfer;

  localparam int WORD_W = 32;
  localparam int BUS_W  = 8;
  localparam int NCH    = 2;
  localparam int BEATS  = WORD_W / BUS_W;
  localparam int TOTAL  = NCH * BEATS;

  logic                  clk = 1'b0;
  logic                  clk_en = 1'b1;
  logic                  rst_n = 1'b0;
  logic                  clear_i = 1'b0;
  logic                  wr_strobe_i = 1'b0;
  logic [BUS_W-1:0]      wr_data_i = '0;
  logic [WORD_W-1:0]     word_o;
  logic                  word_valid_o;
  logic                  rd_strobe_i = 1'b0;
  logic [NCH*WORD_W-1:0] rd_chan_i = '0;
  logic [BUS_W-1:0]      rd_data_o;
  logic                  rd_last_o;

  ptp_xfer #(.WORD_W(WORD_W), .BUS_W(BUS_W), .NCH(NCH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear_i),
    .wr_strobe_i  (wr_strobe_i),
    .wr_data_i    (wr_data_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .rd_strobe_i  (rd_strobe_i),
    .rd_chan_i    (rd_chan_i),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o)
  );

  always #5 if (clk_en) clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: beats collected in a queue, read position as a frame offset.
  logic [BUS_W-1:0]  m_beats[$];
  logic [WORD_W-1:0] m_word;
  logic              m_valid;
  logic [WORD_W-1:0] m_shadow[NCH];
  int                m_pos;
  logic              m_frozen;
  logic              m_wr_prev, m_rd_prev;

  task automatic model_reset();
    m_beats.delete();
    m_word = '0; m_valid = 1'b0; m_pos = 0; m_frozen = 1'b0;
    m_wr_prev = 1'b0; m_rd_prev = 1'b0;
    for (int c = 0; c < NCH; c++) m_shadow[c] = '0;
  endtask

  task automatic model_clock();
    logic wr_e, rd_e;
    logic [WORD_W-1:0] w;
    wr_e = wr_strobe_i && !m_wr_prev;
    rd_e = rd_strobe_i && !m_rd_prev;
    m_wr_prev = wr_strobe_i;
    m_rd_prev = rd_strobe_i;
    m_valid = 1'b0;
    if (!m_frozen)
      for (int c = 0; c < NCH; c++) m_shadow[c] = rd_chan_i[c*WORD_W +: WORD_W];
    if (clear_i) begin
      m_beats.delete();
      m_word = '0; m_pos = 0; m_frozen = 1'b0;
    end else begin
      if (wr_e) begin
        m_beats.push_back(wr_data_i);
        if (m_beats.size() == BEATS) begin
          w = '0;
          for (int k = 0; k < BEATS; k++) w = w | (WORD_W'(m_beats[k]) << (BUS_W * k));
          m_word = w; m_valid = 1'b1;
          m_beats.delete();
        end
      end
      if (rd_e) begin
        m_pos = (m_pos + 1) % TOTAL;
        m_frozen = (m_pos != 0);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [WORD_W-1:0] sw;
    sw = m_shadow[m_pos / BEATS] >> (BUS_W * (m_pos % BEATS));
    check({tag, ".word"},  64'(word_o),       64'(m_word));
    check({tag, ".valid"}, 64'(word_valid_o), 64'(m_valid));
    check({tag, ".rdata"}, 64'(rd_data_o),    64'(sw[BUS_W-1:0]));
    check({tag, ".last"},  64'(rd_last_o),    64'(m_pos == TOTAL - 1));
  endtask

  // Drive inputs (caller sits away from posedge), clock once, compare.
  task automatic step(input string tag, input logic clr, input logic wr,
                      input logic [BUS_W-1:0] wd, input logic rd);
    clear_i = clr; wr_strobe_i = wr; wr_data_i = wd; rd_strobe_i = rd;
    @(posedge clk);
    #1;
    model_clock();
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic wr_beat(input string tag, input logic [BUS_W-1:0] d);
    step(tag, 1'b0, 1'b1, d, 1'b0);
    step(tag, 1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic rd_beat(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b1);
    step(tag, 1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [BUS_W-1:0] exp_rd[TOTAL+1];

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.word",  64'(word_o),       64'h0);
    check("rst.valid", 64'(word_valid_o), 64'h0);
    check("rst.rdata", 64'(rd_data_o),    64'h0);
    check("rst.last",  64'(rd_last_o),    64'h0);
    rst_n = 1'b1;

    // Assemble 0x12345678 from four beats.
    wr_beat("w0", 8'h78);
    wr_beat("w1", 8'h56);
    wr_beat("w2", 8'h34);
    check("w.partial", 64'(word_o), 64'h0);
    step("w3", 1'b0, 1'b1, 8'h12, 1'b0);
    check("w.word", 64'(word_o), 64'h12345678);
    check("w.pulse", 64'(word_valid_o), 64'h1);
    step("w3b", 1'b0, 1'b0, 8'h12, 1'b0);
    check("w.pulse_end", 64'(word_valid_o), 64'h0);

    // Two-channel read frame with freeze after the first edge.
    rd_chan_i = {32'hCAFEBABE, 32'h0000001F};
    step("r.load", 1'b0, 1'b0, '0, 1'b0);
    exp_rd = '{8'h1F, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h1F};
    check("r.b0", 64'(rd_data_o), 64'(exp_rd[0]));
    for (int i = 1; i <= TOTAL; i++) begin
      rd_beat("r");
      if (i == 2) rd_chan_i = {32'h00000000, 32'h0000001F};
      check("r.seq", 64'(rd_data_o), 64'(exp_rd[i]));
      check("r.lastseq", 64'(rd_last_o), 64'(i == TOTAL - 1));
    end
    rd_chan_i = {32'h11223344, 32'h000000A5};
    step("r.track", 1'b0, 1'b0, '0, 1'b0);
    check("r.track_abs", 64'(rd_data_o), 64'hA5);

    // Clear coincident with a third beat, then a fresh word.
    wr_beat("c0", 8'hAA);
    wr_beat("c1", 8'hBB);
    step("c.clr", 1'b1, 1'b1, 8'hCC, 1'b0);
    check("c.word0", 64'(word_o), 64'h0);
    step("c.rel", 1'b0, 1'b0, 8'hCC, 1'b0);
    wr_beat("c2", 8'h01);
    wr_beat("c3", 8'h02);
    wr_beat("c4", 8'h03);
    wr_beat("c5", 8'h04);
    check("c.word", 64'(word_o), 64'h04030201);

    // Held strobe gives a single edge; simultaneous read and write edges.
    step("h0", 1'b0, 1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 6; i++) step("h", 1'b0, 1'b1, 8'h77, 1'b1);
    step("h1", 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) rd_chan_i = {$urandom, $urandom};
      step("rnd", ($urandom_range(0, 40) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-read with the clock stopped.
    rd_chan_i = {32'hDEADBEEF, 32'h5A5A5A5A};
    wr_beat("a0", 8'h11); wr_beat("a1", 8'h22); wr_beat("a2", 8'h33); wr_beat("a3", 8'h44);
    step("a.idle", 1'b0, 1'b0, '0, 1'b0);
    rd_beat("a.r"); rd_beat("a.r"); rd_beat("a.r"); rd_beat("a.r");
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("a.rdata", 64'(rd_data_o),    64'h0);
    check("a.word",  64'(word_o),       64'h0);
    check("a.last",  64'(rd_last_o),    64'h0);
    check("a.valid", 64'(word_valid_o), 64'h0);
    model_reset();

    // Strobe already high when reset releases counts as the first beat.
    wr_strobe_i = 1'b1; wr_data_i = 8'hE1;
    #3 rst_n = 1'b1;
    clk_en = 1'b1;
    step("a.held", 1'b0, 1'b1, 8'hE1, 1'b0);
    step("a.h2", 1'b0, 1'b0, 8'hE1, 1'b0);
    wr_beat("a4", 8'hE2); wr_beat("a5", 8'hE3);
    step("a6", 1'b0, 1'b1, 8'hE4, 1'b0);
    check("a.word_abs", 64'(word_o), 64'hE4E3E2E1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ptp_xfer.md
PTP_XFER -- requirements
Module: ptp_xfer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning word width in bits; WORD_W is a multiple of BUS_W.
REQ-002 SHALL have parameter BUS_W, default 8, meaning byte-lane width in bits.
REQ-003 SHALL have parameter NCH, default 2, meaning number of read channels; NCH >= 1 and WORD_W/BUS_W (BEATS) >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear, active high.
REQ-007 SHALL have port wr_strobe_i  input  1  write beat strobe; each rising edge loads one beat.
REQ-008 SHALL have port wr_data_i  input  BUS_W  write beat data.
REQ-009 SHALL have port word_o  output  WORD_W  last completed assembled word.
REQ-010 SHALL have port word_valid_o  output  1  one-cycle pulse when word_o updates.
REQ-011 SHALL have port rd_strobe_i  input  1  read beat strobe; each rising edge advances one beat.
REQ-012 SHALL have port rd_chan_i  input  NCH*WORD_W  read channels; channel c at bits [c*WORD_W +: WORD_W].
REQ-013 SHALL have port rd_data_o  output  BUS_W  current read beat.
REQ-014 SHALL have port rd_last_o  output  1  high while the final beat of the final channel is presented.

Function
REQ-015 SHALL detect strobe rising edges by comparison with the previously sampled value; a strobe held high produces exactly one edge.
REQ-016 SHALL place write beat k (k = 0..BEATS-1) at staging bits [k*BUS_W +: BUS_W], beat 0 least significant.
REQ-017 SHALL, on the edge of the final beat, load word_o with the full word (final beat plus staged beats) in that same clock edge and pulse word_valid_o for exactly the following cycle; then reset the write beat counter to 0.
REQ-018 SHALL hold word_o unchanged while a partial word is being staged.
REQ-019 SHALL keep a read pointer (channel 0..NCH-1, beat 0..BEATS-1); rd_data_o = shadow[chan][beat*BUS_W +: BUS_W], combinational from registered pointer and shadow.
REQ-020 SHALL advance the read pointer beat-first on each read edge: beat BEATS-1 wraps to 0 with chan+1; (NCH-1, BEATS-1) wraps to (0, 0).
REQ-021 SHALL load the shadow register from rd_chan_i every cycle while the read frame is idle (pointer at (0,0) and no beat consumed) and freeze it from the first read edge until the frame wraps to (0,0).
REQ-022 SHALL operate write and read paths independently; simultaneous write and read edges are both honoured in the same cycle.
REQ-023 SHALL give clear_i priority over strobe edges in the same cycle: write beat counter, staging, word_o, word_valid_o and read pointer go to 0, the frame becomes idle, and edge-detect history still updates so a held strobe does not retrigger.

Reset
REQ-024 SHALL, while rst_n is low and without waiting for clk, force word_o = 0, word_valid_o = 0, staging = 0, shadow = 0 (so rd_data_o = 0), rd_last_o = 0, pointers = 0, edge-detect and synchroniser flops = 0.
REQ-025 SHALL treat a strobe already high at reset release as one rising edge.

Configuration
REQ-026 SHALL, when PTP_XFER_SYNC_EN is defined, pass wr_strobe_i and rd_strobe_i through two-flop synchronisers before edge detection, adding 2 clk cycles of edge-to-effect latency.
REQ-027 SHALL, when PTP_XFER_SYNC_EN is undefined, edge-detect strobes directly; effect occurs at the first clk edge sampling the strobe high; wr_data_i sampling is unaffected by the macro.

Verification (defaults, macro undefined unless stated)
REQ-028 SHALL cover: write beats 0x78,0x56,0x34,0x12 -> word_o = 0x12345678, word_valid_o high one cycle after 4th edge, word_o unchanged after beats 1-3.
REQ-029 SHALL cover: rd_chan_i ch0 = 0x0000001F, ch1 = 0xCAFEBABE, 8 read edges -> rd_data_o 1F,00,00,00,BE,BA,FE,CA; rd_last_o high only at CA; 9th edge -> 1F.
REQ-030 SHALL cover: ch1 changed to 0x00000000 after 2nd read edge -> beats 5-8 still BE,BA,FE,CA; after wrap, rd_data_o tracks new values.
REQ-031 SHALL cover: 2 write beats, then clear_i coincident with a 3rd edge -> beat ignored, word_o = 0; next beats 0x01,0x02,0x03,0x04 -> word_o = 0x04030201.
REQ-032 SHALL cover: rst_n dropped mid-read with clk stopped -> rd_data_o, word_o, rd_last_o read 0 immediately.
REQ-033 SHALL cover: PTP_XFER_SYNC_EN defined, wr_strobe_i held high 10 cycles -> exactly one beat, captured 2 cycles later than macro-undefined build.
